// File: rtl/register_file.sv
// Eight-entry register file with two combinational read ports, one clocked write port,
// and a continuous view of every register (R7 is the program counter by convention).
module register_file #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              rf_rst,
  input  logic [2:0]        a1,
  input  logic [2:0]        a2,
  output logic [DATA_W-1:0] rf1,
  output logic [DATA_W-1:0] rf2,
  input  logic [2:0]        a3,
  input  logic [DATA_W-1:0] rf3,
  input  logic              rf_wr_en,
  output logic [DATA_W-1:0] reg_0,
  output logic [DATA_W-1:0] reg_1,
  output logic [DATA_W-1:0] reg_2,
  output logic [DATA_W-1:0] reg_3,
  output logic [DATA_W-1:0] reg_4,
  output logic [DATA_W-1:0] reg_5,
  output logic [DATA_W-1:0] reg_6,
  output logic [DATA_W-1:0] reg_7
);

  // Declaration initializer gives the zero power-up value before any reset is applied.
  logic [DATA_W-1:0] regs [8] = '{default: '0};

  always_ff @(posedge clock or posedge rf_rst) begin
    if (rf_rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_wr_en) begin
      regs[a3] <= rf3;
    end
  end

  // No write bypass: a read of the target register shows the new value only after the edge.
  assign rf1 = regs[a1];
  assign rf2 = regs[a2];

  assign reg_0 = regs[0];
  assign reg_1 = regs[1];
  assign reg_2 = regs[2];
  assign reg_3 = regs[3];
  assign reg_4 = regs[4];
  assign reg_5 = regs[5];
  assign reg_6 = regs[6];
  assign reg_7 = regs[7];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset behaviour, writes, enable gating,
// read-during-write ordering and the R0/R7 registers.
module tb_register_file;

  logic        clock = 1'b0;
  logic        rf_rst = 1'b0;
  logic [2:0]  a1 = '0;
  logic [2:0]  a2 = '0;
  logic [2:0]  a3 = '0;
  logic [15:0] rf3 = '0;
  logic        rf_wr_en = 1'b0;
  logic [15:0] rf1, rf2;
  logic [15:0] reg_0, reg_1, reg_2, reg_3, reg_4, reg_5, reg_6, reg_7;
  logic [15:0] regView [8];

  int checkCount = 0;
  int failCount = 0;

  register_file #(.DATA_W(16)) dut (
    .clock(clock), .rf_rst(rf_rst),
    .a1(a1), .a2(a2), .rf1(rf1), .rf2(rf2),
    .a3(a3), .rf3(rf3), .rf_wr_en(rf_wr_en),
    .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3),
    .reg_4(reg_4), .reg_5(reg_5), .reg_6(reg_6), .reg_7(reg_7)
  );

  assign regView[0] = reg_0;
  assign regView[1] = reg_1;
  assign regView[2] = reg_2;
  assign regView[3] = reg_3;
  assign regView[4] = reg_4;
  assign regView[5] = reg_5;
  assign regView[6] = reg_6;
  assign regView[7] = reg_7;

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One write: inputs change on the falling edge, results are sampled 1 ns after the rising edge.
  task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clock);
    a3 = addr;
    rf3 = data;
    rf_wr_en = 1'b1;
    @(posedge clock);
    #1;
    rf_wr_en = 1'b0;
  endtask

  initial begin
    #1;
    checkOutput("powerup_reg_0", reg_0, 16'h0000);
    checkOutput("powerup_reg_7", reg_7, 16'h0000);

    @(negedge clock);
    rf_rst = 1'b1;
    @(negedge clock);
    rf_rst = 1'b0;

    applyStimulus(3'd3, 16'h1234);
    applyStimulus(3'd5, 16'hABCD);
    a1 = 3'd3;
    a2 = 3'd5;
    #1;
    checkOutput("wr_rf1_r3", rf1, 16'h1234);
    checkOutput("wr_rf2_r5", rf2, 16'hABCD);
    checkOutput("wr_reg_3", reg_3, 16'h1234);
    checkOutput("wr_reg_5", reg_5, 16'hABCD);

    applyStimulus(3'd2, 16'h0F0F);
    @(negedge clock);
    rf_wr_en = 1'b0;
    a3 = 3'd2;
    rf3 = 16'hFFFF;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("noen_reg_2", reg_2, 16'h0F0F);
    checkOutput("noen_reg_3", reg_3, 16'h1234);

    applyStimulus(3'd6, 16'h0001);
    @(negedge clock);
    a1 = 3'd6;
    a3 = 3'd6;
    rf3 = 16'h0002;
    rf_wr_en = 1'b1;
    #1;
    checkOutput("rdw_before_edge", rf1, 16'h0001);
    @(posedge clock);
    #1;
    rf_wr_en = 1'b0;
    checkOutput("rdw_after_edge", rf1, 16'h0002);

    applyStimulus(3'd1, 16'h1111);
    applyStimulus(3'd1, 16'h2222);
    checkOutput("consec_reg_1", reg_1, 16'h2222);

    applyStimulus(3'd0, 16'h8000);
    applyStimulus(3'd7, 16'h00FF);
    a1 = 3'd7;
    a2 = 3'd7;
    #1;
    checkOutput("r0_reg_0", reg_0, 16'h8000);
    checkOutput("r7_reg_7", reg_7, 16'h00FF);
    checkOutput("r7_rf1", rf1, 16'h00FF);
    checkOutput("r7_rf2", rf2, 16'h00FF);

    // Reset pulse placed between edges must clear everything without a clock.
    @(negedge clock);
    #2;
    rf_rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("async_rst_reg_%0d", k), regView[k], 16'h0000);
    end
    checkOutput("async_rst_rf1", rf1, 16'h0000);
    checkOutput("async_rst_rf2", rf2, 16'h0000);
    rf_rst = 1'b0;

    applyStimulus(3'd5, 16'h0A0A);
    checkOutput("post_rst_first_write", reg_5, 16'h0A0A);

    applyStimulus(3'd4, 16'h4444);
    checkOutput("pre_rvw_reg_4", reg_4, 16'h4444);
    @(negedge clock);
    a3 = 3'd4;
    rf3 = 16'h5555;
    rf_wr_en = 1'b1;
    rf_rst = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rst_vs_write_reg_4", reg_4, 16'h0000);
    a1 = 3'd4;
    #1;
    checkOutput("rst_hold_rf1", rf1, 16'h0000);
    @(negedge clock);
    rf_wr_en = 1'b0;
    rf_rst = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("after_rvw_reg_4", reg_4, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 16, register and data-port width in bits.
REQ-002 The block SHALL have a clock port: clock, input, 1 bit, only clock, rising-edge active.
REQ-003 The block SHALL have a reset port: rf_rst, input, 1 bit; one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have a1, input, 3 bits, read-port-1 register address.
REQ-005 The block SHALL have a2, input, 3 bits, read-port-2 register address.
REQ-006 The block SHALL have rf1, output, DATA_W, read-port-1 data.
REQ-007 The block SHALL have rf2, output, DATA_W, read-port-2 data.
REQ-008 The block SHALL have a3, input, 3 bits, write-port register address.
REQ-009 The block SHALL have rf3, input, DATA_W, write-port data.
REQ-010 The block SHALL have rf_wr_en, input, 1 bit, write enable, active-high.
REQ-011 The block SHALL have reg_0 … reg_7, outputs, DATA_W each, continuous view of registers R0…R7 (R7 = program counter by convention).

Function
REQ-012 The block SHALL hold eight DATA_W-bit registers R0…R7; none is hardwired, and R0 and R7 are writable like any other.
REQ-013 Reads SHALL be combinational: rf1 = R[a1] and rf2 = R[a2] in the same cycle the address changes, with no clock needed.
REQ-014 Both read ports SHALL be independent; a1 == a2 returns the same value on rf1 and rf2.
REQ-015 A write SHALL occur on the rising clock edge when rf_wr_en = 1 and rf_rst = 0: R[a3] <= rf3; all other registers are unchanged.
REQ-016 When rf_wr_en = 0, no register SHALL change on the clock edge, regardless of a3 and rf3.
REQ-017 Read-during-write SHALL be write-first after the edge only: before the edge, a read of R[a3] returns the old value; after the edge, it returns rf3 (no internal bypass).
REQ-018 Each reg_k output SHALL equal Rk at all times and update together with the write edge.
REQ-019 Every address value 0…7 SHALL be valid; there is no out-of-range condition.
REQ-020 Writes on consecutive edges to the same register SHALL leave the last written value.

Reset
REQ-021 rf_rst = 1 SHALL clear R0…R7 to 0 immediately, asynchronously, without waiting for a clock edge.
REQ-022 While rf_rst = 1, writes SHALL be ignored and all registers SHALL hold 0; rf1, rf2 and reg_0…reg_7 SHALL read 0.
REQ-023 After rf_rst is deasserted, the first write SHALL take effect on the first rising edge with rf_wr_en = 1.
REQ-024 Asserting rf_rst on the same edge as a write SHALL leave the target register at 0 (reset wins).
REQ-025 Register contents before the first reset SHALL also be 0 (power-up initial value 0).

Verification
REQ-026 Reset test: drive rf_rst pulse mid-cycle with no clock edge -> reg_0…reg_7, rf1 and rf2 go to 0x0000 immediately.
REQ-027 Write/read test: write 0x1234 to R3 and 0xABCD to R5; set a1=3, a2=5 -> rf1 = 0x1234, rf2 = 0xABCD, reg_3 = 0x1234, reg_5 = 0xABCD.
REQ-028 Enable test: rf_wr_en = 0, a3 = 2, rf3 = 0xFFFF, clock 3 edges -> reg_2 stays at its prior value.
REQ-029 Read-during-write test: R6 = 0x0001, a1 = a3 = 6, rf3 = 0x0002, rf_wr_en = 1 -> rf1 = 0x0001 before the edge and 0x0002 after it.
REQ-030 R0/R7 test: write 0x8000 to R0 and 0x00FF to R7 -> reg_0 = 0x8000, reg_7 = 0x00FF; a1=a2=7 gives rf1 = rf2 = 0x00FF.
REQ-031 Reset-vs-write test: rf_rst = 1 coincident with a write of 0x5555 to R4 -> reg_4 = 0x0000.
